deserializer: RTL

Receive-side counterpart of the audio output serializer. It generates the microphone bit clock from the system clock, samples the 1-bit microphone data line once per bit period, and assembles WORD_LENGTH samples MSB-first into a parallel word. Each completed word is offered downstream on a valid/ready handshake, with a sticky overrun flag if the consumer falls behind. It sits between the microphone pins and the sample buffer/processing logic.

---
 rtl/deserializer_if.sv | 15 +
 rtl/deserializer.sv | 96 +++++++++
 2 files changed

// File: rtl/deserializer_if.sv
// deserializer_if: parallel word handshake from deserializer to consumer
//   data_o     assembled word, first sampled bit in the MSB
//   valid_o    data_o holds an unconsumed word
//   ready_i    consumer accepts data_o when valid_o && ready_i
//   overrun_o  sticky, a word was overwritten before it was accepted
interface deserializer_if #(
  parameter int WORD_LENGTH = 16
);
  logic [WORD_LENGTH-1:0] data_o;
  logic                   valid_o;
  logic                   ready_i;
  logic                   overrun_o;
  modport master (output data_o, valid_o, overrun_o, input ready_i);
  modport slave  (input data_o, valid_o, overrun_o, output ready_i);
endinterface

// File: rtl/deserializer.sv
// deserializer: PDM microphone receiver, bit clock generation and MSB-first word assembly
//   clock_i      system clock, all logic on its rising edge
//   reset_n_i    asynchronous active-low reset
//   enable_i     run when high, synchronous clear when low (data_o holds)
//   pdm_data_i   microphone data line
//   pdm_clock_o  microphone bit clock, period 2*HALF system cycles
//   out_if       word handshake (data_o, valid_o, ready_i, overrun_o)
// Define DESERIALIZER_SYNC_EN to put a two-flop synchronizer on pdm_data_i.
module deserializer #(
  parameter int WORD_LENGTH        = 16,
  parameter int SYSTEM_FREQUENCY   = 100000000,
  parameter int SAMPLING_FREQUENCY = 1000000
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic enable_i,
  input  logic pdm_data_i,
  output logic pdm_clock_o,
  deserializer_if.master out_if
);
  localparam int HALF = (SYSTEM_FREQUENCY / SAMPLING_FREQUENCY) / 2;
  localparam int DW   = (HALF > 2) ? $clog2(HALF) : 1;
  localparam int BW   = (WORD_LENGTH > 2) ? $clog2(WORD_LENGTH) : 1;
  if (HALF < 2) begin : g_half_check
    $error("deserializer: SYSTEM_FREQUENCY/SAMPLING_FREQUENCY must be at least 4");
  end
  logic [DW-1:0]          div_q, div_d;
  logic                   pclk_q, pclk_d;
  logic [BW-1:0]          bcnt_q, bcnt_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic                   load_q, load_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ovr_q, ovr_d;
  logic                   div_wrap, strobe, sample_bit;
`ifdef DESERIALIZER_SYNC_EN
  logic [1:0] sync_q, sync_d;
  assign sync_d     = enable_i ? {sync_q[0], pdm_data_i} : 2'b00;
  assign sample_bit = sync_q[1];
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) sync_q <= 2'b00;
    else            sync_q <= sync_d;
  end
`else
  assign sample_bit = pdm_data_i;
`endif
  assign div_wrap = div_q == DW'(HALF - 1);
  // sampling happens on the rising toggle of the bit clock
  assign strobe   = div_wrap && !pclk_q;
  always_comb begin
    div_d   = div_wrap ? '0 : div_q + DW'(1);
    pclk_d  = pclk_q ^ div_wrap;
    shift_d = strobe ? {shift_q[WORD_LENGTH-2:0], sample_bit} : shift_q;
    bcnt_d  = !strobe ? bcnt_q : (bcnt_q == BW'(WORD_LENGTH - 1)) ? '0 : bcnt_q + BW'(1);
    // word complete flag; the full shift register is transferred one edge later
    load_d  = strobe && (bcnt_q == BW'(WORD_LENGTH - 1));
    data_d  = (load_q && enable_i) ? shift_q : data_q;
    // a fresh word keeps valid high even when the old one is accepted on the same edge
    valid_d = load_q || (valid_q && !out_if.ready_i);
    ovr_d   = ovr_q || (load_q && valid_q && !out_if.ready_i);
    if (!enable_i) begin
      div_d   = '0;
      pclk_d  = 1'b0;
      shift_d = '0;
      bcnt_d  = '0;
      load_d  = 1'b0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      div_q   <= '0;
      pclk_q  <= 1'b0;
      bcnt_q  <= '0;
      shift_q <= '0;
      load_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      pclk_q  <= pclk_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      load_q  <= load_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end
  assign pdm_clock_o      = pclk_q;
  assign out_if.data_o    = data_q;
  assign out_if.valid_o   = valid_q;
  assign out_if.overrun_o = ovr_q;
endmodule
